// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned SEL_W   = 2;

    // Controller states (4-bit encoding).
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    // Opcodes.
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    // ALU decoder requests.
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand sources.
    localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    // PC next-value sources.
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control bundle.
    typedef struct packed {
        logic               memreq;
        logic               pcwrite;
        logic               branch;
        logic               iord;
        logic               memwrite;
        logic               irwrite;
        logic               regdst;
        logic               memtoreg;
        logic               regwrite;
        logic               alusrca;
        logic [SEL_W-1:0]   alusrcb;
        logic [SEL_W-1:0]   pcsrc;
        logic [ALUOP_W-1:0] aluop;
        logic               bad_op;
    } ctrl_t;

    // States that issue a memory request and may wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating memory-wait counter with a sticky timeout flag.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on access entry, else count waiting cycles up to LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM with memory handshake and wait watchdog.
// Optional bne support: define MC_CONTROLLER_BNE_EN to add state BNEEX and port branch_ne.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             memreq,
    output logic             pcwrite,
    output logic             branch,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [SEL_W-1:0] alusrcb,
    output logic [SEL_W-1:0] pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic             mem_timeout,
    output logic             bad_op
`ifdef MC_CONTROLLER_BNE_EN
    ,
    output logic             branch_ne
`endif
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   wait_clear;
    logic   wait_count;
`ifdef MC_CONTROLLER_BNE_EN
    logic   bne;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
`ifdef MC_CONTROLLER_BNE_EN
        bne     = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                ctrl.memreq  = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                if (mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH2;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default: begin
                        ctrl.bad_op = 1'b1;
                        state_d     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                state_d      = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.memreq = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                state_d       = FETCH;
            end
            MEMWR: begin
                ctrl.memreq   = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
                state_d      = RTYPEWB;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                state_d       = FETCH;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                state_d      = FETCH;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                state_d      = ADDIWB;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
                state_d       = FETCH;
            end
            JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
                state_d      = FETCH;
            end
`ifdef MC_CONTROLLER_BNE_EN
            BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                bne          = 1'b1;
                state_d      = FETCH;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset forces every control low at once, dropping an in-flight memreq.
    assign ctrl_out = reset ? ctrl : '0;

    assign memreq   = ctrl_out.memreq;
    assign pcwrite  = ctrl_out.pcwrite;
    assign branch   = ctrl_out.branch;
    assign iord     = ctrl_out.iord;
    assign memwrite = ctrl_out.memwrite;
    assign irwrite  = ctrl_out.irwrite;
    assign regdst   = ctrl_out.regdst;
    assign memtoreg = ctrl_out.memtoreg;
    assign regwrite = ctrl_out.regwrite;
    assign alusrca  = ctrl_out.alusrca;
    assign alusrcb  = ctrl_out.alusrcb;
    assign pcsrc    = ctrl_out.pcsrc;
    assign aluop    = ctrl_out.aluop;
    assign bad_op   = ctrl_out.bad_op;
`ifdef MC_CONTROLLER_BNE_EN
    assign branch_ne = reset & bne;
`endif

    // Wait counter restarts on entry to a memory state, counts stalled cycles.
    assign wait_clear = is_mem_state(state_d) && (state_d != state_q);
    assign wait_count = is_mem_state(state_q) && !mem_ready;

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .count   (wait_count),
        .timeout (mem_timeout)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus randomized programs.
module tb_mc_controller;

    localparam int MAX_W = 4;

    // Phase names of an instruction's life, taken from the controller's action table.
    localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5;
    localparam int PH_RE = 6, PH_RWB = 7, PH_BE = 8, PH_AE = 9, PH_AWB = 10, PH_J = 11, PH_BNE = 12;

    typedef struct packed {
        logic       branch_ne;
        logic       memreq;
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       bad_op;
    } ctl_t;

    typedef struct {
        int         ph;
        bit         rdy;
        int         widx;
        logic [5:0] op;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       memreq, pcwrite, branch, iord, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       mem_timeout, bad_op;
`ifdef MC_CONTROLLER_BNE_EN
    logic       branch_ne;
`endif

    int    checks = 0;
    int    errors = 0;
    int    idle_mode = 1;
    bit    to_model = 1'b0;
    step_t seq_q[$];
    ctl_t  obs_q[$];

    mc_controller #(.MAX_WAIT(MAX_W), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .mem_ready   (mem_ready),
        .memreq      (memreq),
        .pcwrite     (pcwrite),
        .branch      (branch),
        .iord        (iord),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .aluop       (aluop),
        .mem_timeout (mem_timeout),
        .bad_op      (bad_op)
`ifdef MC_CONTROLLER_BNE_EN
        ,
        .branch_ne   (branch_ne)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic bit supported(input logic [5:0] o);
        case (o)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_CONTROLLER_BNE_EN
            6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_mem(input int ph);
        return (ph == PH_F) || (ph == PH_MR) || (ph == PH_MW);
    endfunction

    // Expected controls for one cycle of a phase.
    function automatic ctl_t exp_vec(input int ph, input bit rdy, input logic [5:0] o);
        ctl_t e = '0;
        case (ph)
            PH_F:   begin e.memreq = 1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy; end
            PH_D:   begin e.alusrcb = 2'b11; e.bad_op = !supported(o); end
            PH_MA:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            PH_MR:  begin e.memreq = 1; e.iord = 1; end
            PH_MWB: begin e.memtoreg = 1; e.regwrite = 1; end
            PH_MW:  begin e.memreq = 1; e.iord = 1; e.memwrite = 1; end
            PH_RE:  begin e.alusrca = 1; e.aluop = 2'b10; end
            PH_RWB: begin e.regdst = 1; e.regwrite = 1; end
            PH_BE:  begin e.alusrca = 1; e.aluop = 2'b01; e.branch = 1; e.pcsrc = 2'b01; end
            PH_AE:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            PH_AWB: begin e.regwrite = 1; end
            PH_J:   begin e.pcsrc = 2'b10; e.pcwrite = 1; end
            PH_BNE: begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch_ne = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t observe();
        ctl_t o;
        o.memreq = memreq;   o.pcwrite = pcwrite;   o.branch = branch;
        o.iord = iord;       o.memwrite = memwrite; o.irwrite = irwrite;
        o.regdst = regdst;   o.memtoreg = memtoreg; o.regwrite = regwrite;
        o.alusrca = alusrca; o.alusrcb = alusrcb;   o.pcsrc = pcsrc;
        o.aluop = aluop;     o.bad_op = bad_op;
`ifdef MC_CONTROLLER_BNE_EN
        o.branch_ne = branch_ne;
`else
        o.branch_ne = 1'b0;
`endif
        return o;
    endfunction

    function automatic bit idle_rdy();
        if (idle_mode == 2) return 1'($urandom_range(0, 1));
        return idle_mode[0];
    endfunction

    function automatic void push(input int ph, input bit rdy, input int widx, input logic [5:0] o);
        step_t s;
        s.ph = ph; s.rdy = rdy; s.widx = widx; s.op = o;
        seq_q.push_back(s);
    endfunction

    // A memory access: w stalled cycles, then the ready cycle.
    function automatic void push_mem(input int ph, input int w, input logic [5:0] o);
        for (int i = 0; i < w; i++) push(ph, 1'b0, i, o);
        push(ph, 1'b1, w, o);
    endfunction

    // Expected cycle-by-cycle phases of one instruction.
    function automatic void build_seq(input logic [5:0] o, input int fw, input int mw);
        push_mem(PH_F, fw, o);
        push(PH_D, idle_rdy(), 0, o);
        if (supported(o)) begin
            case (o)
                6'b100011: begin push(PH_MA, idle_rdy(), 0, o); push_mem(PH_MR, mw, o);
                                 push(PH_MWB, idle_rdy(), 0, o); end
                6'b101011: begin push(PH_MA, idle_rdy(), 0, o); push_mem(PH_MW, mw, o); end
                6'b000000: begin push(PH_RE, idle_rdy(), 0, o); push(PH_RWB, idle_rdy(), 0, o); end
                6'b000100: push(PH_BE, idle_rdy(), 0, o);
                6'b001000: begin push(PH_AE, idle_rdy(), 0, o); push(PH_AWB, idle_rdy(), 0, o); end
                6'b000010: push(PH_J, idle_rdy(), 0, o);
                default:   push(PH_BNE, idle_rdy(), 0, o);
            endcase
        end
    endfunction

    // Drive the queued program one cycle at a time and compare every cycle.
    task automatic run_seq(input string name);
        ctl_t o;
        ctl_t e;
        obs_q.delete();
        foreach (seq_q[i]) begin
            @(negedge clk);
            op = seq_q[i].op;
            mem_ready = seq_q[i].rdy;
            #1;
            o = observe();
            obs_q.push_back(o);
            e = exp_vec(seq_q[i].ph, seq_q[i].rdy, seq_q[i].op);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cyc %0d ctl got %h exp %h", name, i, o, e);
            end
            checks++;
            if (mem_timeout !== to_model) begin
                errors++;
                $display("FAIL %s cyc %0d mem_timeout got %b exp %b", name, i, mem_timeout, to_model);
            end
            if (is_mem(seq_q[i].ph) && !seq_q[i].rdy && (seq_q[i].widx + 1 >= MAX_W)) to_model = 1'b1;
        end
        seq_q.delete();
    endtask

    task automatic test_reset();
        ctl_t e;
        reset = 1'b0; op = 6'd0; mem_ready = 1'b0;
        #3;
        checks++;
        if (observe() !== ctl_t'('0)) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", observe());
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout);
        end
        @(posedge clk); #2 reset = 1'b1; #1;
        e = exp_vec(PH_F, 1'b0, 6'd0);
        checks++;
        if (observe() !== e) begin
            errors++; $display("FAIL reset_release got %h exp %h", observe(), e);
        end
    endtask

    task automatic test_lw();
        idle_mode = 1;
        build_seq(6'b100011, 0, 0);
        run_seq("lw");
        checks++;
        if (!(obs_q[4].regwrite === 1'b1 && obs_q[4].memtoreg === 1'b1)) begin
            errors++; $display("FAIL lw_wb got rw=%b m2r=%b exp 1 1", obs_q[4].regwrite, obs_q[4].memtoreg);
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].aluop !== 2'b00) begin
                errors++; $display("FAIL lw_aluop cyc %0d got %b exp 00", i, obs_q[i].aluop);
            end
        end
    endtask

    task automatic test_rtype_beq();
        idle_mode = 2;
        build_seq(6'b000000, 0, 0);
        build_seq(6'b000100, 0, 0);
        run_seq("rtype_beq");
        checks++;
        if (obs_q[2].aluop !== 2'b10) begin
            errors++; $display("FAIL rtype_aluop got %b exp 10", obs_q[2].aluop);
        end
        checks++;
        if (obs_q[4].memreq !== 1'b1 || obs_q[4].irwrite !== 1'b1) begin
            errors++; $display("FAIL rtype_len cyc4 memreq %b irwrite %b exp 1 1", obs_q[4].memreq, obs_q[4].irwrite);
        end
        checks++;
        if ({obs_q[6].aluop, obs_q[6].branch, obs_q[6].pcsrc} !== 5'b01101) begin
            errors++; $display("FAIL beq_ex got %b exp 01101", {obs_q[6].aluop, obs_q[6].branch, obs_q[6].pcsrc});
        end
    endtask

    task automatic test_sw_wait();
        idle_mode = 2;
        build_seq(6'b101011, 0, 3);
        build_seq(6'b000010, 0, 0);
        run_seq("sw_wait");
        for (int i = 3; i <= 6; i++) begin
            checks++;
            if (obs_q[i].memreq !== 1'b1 || obs_q[i].memwrite !== 1'b1) begin
                errors++; $display("FAIL sw_hold cyc %0d memreq %b memwrite %b exp 1 1", i, obs_q[i].memreq, obs_q[i].memwrite);
            end
        end
        checks++;
        if (obs_q[7].memreq !== 1'b1 || obs_q[7].iord !== 1'b0) begin
            errors++; $display("FAIL sw_next_fetch memreq %b iord %b exp 1 0", obs_q[7].memreq, obs_q[7].iord);
        end
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL sw_timeout got %b exp 0", mem_timeout);
        end
    endtask

    task automatic test_bad_op();
        idle_mode = 2;
        build_seq(6'b111111, 0, 0);
        build_seq(6'b000010, 0, 0);
        run_seq("bad_op");
        checks++;
        if (obs_q[1].bad_op !== 1'b1 || obs_q[2].bad_op !== 1'b0) begin
            errors++; $display("FAIL bad_op_pulse got %b%b exp 10", obs_q[1].bad_op, obs_q[2].bad_op);
        end
        checks++;
        if (obs_q[2].memreq !== 1'b1 || (obs_q[1].regwrite | obs_q[1].memwrite) !== 1'b0) begin
            errors++; $display("FAIL bad_op_next memreq %b rw %b mw %b exp 1 0 0", obs_q[2].memreq, obs_q[1].regwrite, obs_q[1].memwrite);
        end
    endtask

    task automatic test_reset_mid_access();
        idle_mode = 1;
        push(PH_F, 1'b1, 0, 6'b100011);
        push(PH_D, 1'b1, 0, 6'b100011);
        push(PH_MA, 1'b1, 0, 6'b100011);
        push(PH_MR, 1'b0, 0, 6'b100011);
        run_seq("mid_rd");
        #1 reset = 1'b0;
        #1;
        checks++;
        if (memreq !== 1'b0 || observe() !== ctl_t'('0)) begin
            errors++; $display("FAIL mid_reset_drop memreq %b ctl %h exp 0 0", memreq, observe());
        end
        to_model = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        build_seq(6'b000010, 0, 0);
        run_seq("after_mid_reset");
    endtask

    task automatic test_timeout();
        idle_mode = 2;
        build_seq(6'b000010, 6, 0);
        build_seq(6'b001000, 0, 0);
        run_seq("timeout");
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got %b exp 1", mem_timeout);
        end
        @(posedge clk); #2 reset = 1'b0; #1;
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_clear got %b exp 0", mem_timeout);
        end
        to_model = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b001000, 6'b000010, 6'b000101, 6'b111111};
        logic [5:0] o;
        idle_mode = 2;
        for (int n = 0; n < 40; n++) begin
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            build_seq(o, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end
        run_seq("random");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_beq();
        test_sw_wait();
        test_bad_op();
        test_reset_mid_access();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
